// File: rtl/display_pkg.sv
// Shared constants and scan-state encoding for the multiplexed 7-segment display controller.
package display_pkg;

    localparam int unsigned DEF_N_DIGITS = 8;
    localparam int unsigned DIGIT_W      = 4;
    localparam int unsigned SEL_W        = 3;
    localparam int unsigned SEG_W        = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } scan_state_t;

    // Counter width able to reach the larger of two terminal counts.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, one-clock rising-press pulse.
module btn_debounce
    import display_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CNT_W = cnt_width(DB_CYCLES, 1);

    logic [1:0]       sync_q;
    logic             db_q;
    logic [CNT_W-1:0] cnt_q;
    logic             synced;

    assign synced = sync_q[1];

    // Accept the synced level only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
            db_q   <= 1'b0;
            cnt_q  <= '0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            pulse  <= 1'b0;
            if (synced == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                cnt_q <= '0;
                db_q  <= synced;
                pulse <= synced;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/driver7seg.sv
// BCD to active-low 7-segment decoder, seg_c[0]=a .. seg_c[6]=g; non-BCD codes blank.
module driver7seg
    import display_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd,
    output logic [SEG_W-1:0]   seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (bcd)
            4'd0:    seg_c = 7'b1000000;
            4'd1:    seg_c = 7'b1111001;
            4'd2:    seg_c = 7'b0100100;
            4'd3:    seg_c = 7'b0110000;
            4'd4:    seg_c = 7'b0011001;
            4'd5:    seg_c = 7'b0010010;
            4'd6:    seg_c = 7'b0000010;
            4'd7:    seg_c = 7'b1111000;
            4'd8:    seg_c = 7'b0000000;
            4'd9:    seg_c = 7'b0010000;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// 8-digit BCD display controller: button-driven digit editing plus anode scanning with blanking.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned N_DIGITS     = DEF_N_DIGITS,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 2,
    parameter int unsigned DB_CYCLES    = 500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_sel,
    input  logic                btn_inc,
    output logic [N_DIGITS-1:0] an,
    output logic [SEG_W-1:0]    d,
    output logic                dp,
    output logic [SEL_W-1:0]    cur_sel
);

    localparam int unsigned CNT_W = cnt_width(REFRESH_DIV, BLANK_CYCLES);
    localparam logic [SEL_W-1:0]   LAST_IDX = SEL_W'(N_DIGITS - 1);
    localparam logic [DIGIT_W-1:0] MAX_BCD  = DIGIT_W'(9);

    logic                sel_pulse;
    logic                inc_pulse;
    logic [DIGIT_W-1:0]  digit_q [N_DIGITS];
    logic [DIGIT_W-1:0]  scan_digit;
    logic [SEG_W-1:0]    seg_c;

    scan_state_t         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0]    scan_idx_q, scan_idx_d;
    logic [N_DIGITS-1:0] an_d;
    logic [SEG_W-1:0]    d_d;
    logic                dp_d;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sel (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_sel),
        .pulse (sel_pulse)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_inc),
        .pulse (inc_pulse)
    );

    // Edits: inc targets the cursor as it stood before any simultaneous sel step.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_sel <= '0;
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
                digit_q[i] <= '0;
            end
        end else begin
            if (inc_pulse) begin
                digit_q[cur_sel] <= (digit_q[cur_sel] == MAX_BCD) ? '0
                                                                   : digit_q[cur_sel] + DIGIT_W'(1);
            end
            if (sel_pulse) begin
                cur_sel <= (cur_sel == LAST_IDX) ? '0 : cur_sel + SEL_W'(1);
            end
        end
    end

    assign scan_digit = digit_q[scan_idx_q];

    driver7seg u_dec (
        .bcd   (scan_digit),
        .seg_c (seg_c)
    );

    // Scan state and the display pins share one register stage so anodes and segments switch together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SHOW;
            cnt_q      <= '0;
            scan_idx_q <= '0;
            an         <= '1;
            d          <= SEG_BLANK;
            dp         <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            scan_idx_q <= scan_idx_d;
            an         <= an_d;
            d          <= d_d;
            dp         <= dp_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        scan_idx_d = scan_idx_q;
        an_d       = '1;
        d_d        = SEG_BLANK;
        dp_d       = 1'b1;
        case (state_q)
            SHOW: begin
                an_d = ~(N_DIGITS'(1) << scan_idx_q);
                d_d  = seg_c;
                dp_d = ~(scan_idx_q == cur_sel);
                if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                end
            end
            BLANK: begin
                if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_d    = SHOW;
                    cnt_d      = '0;
                    scan_idx_d = (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + SEL_W'(1);
                end
            end
            default: begin
                state_d = SHOW;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench: a cycle model of scan timing and digit edits queues expected pin values.
module tb_display_scan_ctrl;

    localparam int ND   = 8;
    localparam int RD   = 4;
    localparam int BC   = 1;
    localparam int DB   = 3;
    localparam int SLOT = RD + BC;
    localparam int LAT  = 2 + DB + 1;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] d;
        logic       dp;
        logic [2:0] cur;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_sel = 1'b0;
    logic       btn_inc = 1'b0;
    logic [7:0] an;
    logic [6:0] d;
    logic       dp;
    logic [2:0] cur_sel;

    exp_t exp_q[$];
    int   inc_q[$];
    int   sel_q[$];
    int   cyc = 0;
    int   ph = 0;
    int   m_dig[ND];
    int   m_cur = 0;
    int   checks = 0;
    int   errors = 0;

    display_scan_ctrl #(
        .N_DIGITS     (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC),
        .DB_CYCLES    (DB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_sel (btn_sel),
        .btn_inc (btn_inc),
        .an      (an),
        .d       (d),
        .dp      (dp),
        .cur_sel (cur_sel)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int v);
        logic [6:0] t [10];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return t[v];
    endfunction

    // Reference: outputs after an edge reflect the scan phase and digits held before that edge.
    always @(posedge clk) begin : model
        exp_t e;
        int   slot;
        int   w;
        bit   di;
        bit   ds;
        cyc++;
        e.an = 8'hFF; e.d = 7'h7F; e.dp = 1'b1; e.cur = 3'd0;
        if (rst) begin
            for (int i = 0; i < ND; i++) m_dig[i] = 0;
            m_cur = 0;
            ph = 0;
            inc_q.delete();
            sel_q.delete();
        end else begin
            slot = (ph % (ND * SLOT)) / SLOT;
            w    = ph % SLOT;
            if (w < RD) begin
                e.an[slot] = 1'b0;
                e.d        = seg_of(m_dig[slot]);
                e.dp       = (slot != m_cur);
            end
            di = (inc_q.size() > 0) && (inc_q[0] == cyc);
            ds = (sel_q.size() > 0) && (sel_q[0] == cyc);
            if (di) void'(inc_q.pop_front());
            if (ds) void'(sel_q.pop_front());
            if (di) m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
            if (ds) m_cur = (m_cur + 1) % ND;
            e.cur = 3'(m_cur);
            ph++;
        end
        exp_q.push_back(e);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("an", an, e.an);
            chk("d", 8'(d), 8'(e.d));
            chk("dp", 8'(dp), 8'(e.dp));
            chk("cur_sel", 8'(cur_sel), 8'(e.cur));
        end
    end

    task automatic press(input bit pi, input bit ps, input int hold);
        @(posedge clk); #1;
        btn_inc = pi;
        btn_sel = ps;
        if (hold >= DB) begin
            if (pi) inc_q.push_back(cyc + LAT);
            if (ps) sel_q.push_back(cyc + LAT);
        end
        repeat (hold) @(posedge clk);
        #1;
        btn_inc = 1'b0;
        btn_sel = 1'b0;
        repeat (DB + 5) @(posedge clk);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int r;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2 * ND * SLOT) @(posedge clk);

        press(1'b1, 1'b0, 10);
        repeat (ND * SLOT) @(posedge clk);
        for (int i = 0; i < 9; i++) press(1'b1, 1'b0, int'($urandom_range(3, 6)));
        repeat (ND * SLOT) @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            press(1'b0, 1'b1, int'($urandom_range(3, 6)));
            repeat (ND * SLOT) @(posedge clk);
        end

        for (int i = 0; i < 5; i++) press(1'b1, 1'b0, int'($urandom_range(1, 2)));
        repeat (ND * SLOT) @(posedge clk);

        for (int i = 0; i < 7; i++) press(1'b0, 1'b1, 4);
        press(1'b1, 1'b1, 5);
        repeat (ND * SLOT) @(posedge clk);

        // Land the reset inside a lit slot.
        for (int k = 0; k < SLOT; k++) begin
            if ((ph % SLOT) == 1) break;
            @(posedge clk);
        end
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (ND * SLOT) @(posedge clk);

        for (int it = 0; it < 150; it++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2, 3: press(1'b1, 1'b0, int'($urandom_range(3, 12)));
                4, 5, 6:    press(1'b0, 1'b1, int'($urandom_range(3, 12)));
                7:          press(1'b1, 1'b1, int'($urandom_range(3, 12)));
                8:          press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                  int'($urandom_range(1, 2)));
                default:    do_reset(int'($urandom_range(1, 3)));
            endcase
            repeat ($urandom_range(0, 15)) @(posedge clk);
        end

        repeat (ND * SLOT) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
